vx_dcache_arb: RTL

VX_DCACHE_ARB -- requirements
Module: VX_dcache_arb

---
 rtl/vx_dcache_arb_pkg.sv | 21 ++
 rtl/vx_dcache_arb_rr.sv | 55 +++++
 rtl/vx_dcache_arb.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vx_dcache_arb_pkg.sv
// Shared types and width helpers for the dcache request arbiter.
// The requester select index is appended below the requester tag.
package vx_dcache_arb_pkg;

    localparam int NUM_THREADS     = 4;
    localparam int DCORE_TAG_WIDTH = 9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } arb_state_e;

    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tag_out_width(input int tag_in, input int n);
        return tag_in + sel_bits(n);
    endfunction

endpackage

// File: rtl/vx_dcache_arb_rr.sv
// Round-robin arbiter: one-hot and index grant, pointer moves past the
// winner only when the grant is actually taken (enable_i).
module vx_dcache_arb_rr
    import vx_dcache_arb_pkg::*;
#(
    parameter  int NUM_REQS = 2,
    localparam int SEL_BITS = sel_bits(NUM_REQS)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NUM_REQS-1:0] requests_i,
    input  logic                enable_i,
    output logic                grant_valid_o,
    output logic [NUM_REQS-1:0] grant_onehot_o,
    output logic [SEL_BITS-1:0] grant_index_o
);

    logic [SEL_BITS-1:0] ptr_q;
    logic [SEL_BITS-1:0] ptr_d;

    // Scan downwards so the requester closest to ptr_q is written last.
    always_comb begin
        int j;
        j              = 0;
        grant_valid_o  = 1'b0;
        grant_index_o  = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            j = (int'(ptr_q) + i) % NUM_REQS;
            if (requests_i[j]) begin
                grant_valid_o = 1'b1;
                grant_index_o = SEL_BITS'(j);
            end
        end
    end

    always_comb begin
        grant_onehot_o = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_valid_o && (grant_index_o == SEL_BITS'(i))) begin
                grant_onehot_o[i] = 1'b1;
            end
        end
    end

    assign ptr_d = SEL_BITS'((int'(grant_index_o) + 1) % NUM_REQS);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else if (enable_i && grant_valid_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vx_dcache_arb.sv
// Multi-requester dcache arbiter with per-lane issue and tag-routed responses.
// Optional stall counter port perf_stalls_o when DCACHE_ARB_PERF_EN is defined.
module vx_dcache_arb
    import vx_dcache_arb_pkg::*;
#(
    parameter  int NUM_REQS      = 2,
    parameter  int NUM_LANES     = NUM_THREADS,
    parameter  int TAG_IN_WIDTH  = DCORE_TAG_WIDTH - 1,
    localparam int SEL_BITS      = sel_bits(NUM_REQS),
    localparam int TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_REQS)
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic [NUM_REQS-1:0]                          req_valid_i,
    input  logic [NUM_REQS-1:0]                          req_rw_i,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0]           req_tmask_i,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][3:0]      req_byteen_i,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][29:0]     req_addr_i,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][31:0]     req_data_i,
    input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]        req_tag_i,
    output logic [NUM_REQS-1:0]                          req_ready_o,
    output logic [NUM_LANES-1:0]                         dcache_req_valid_o,
    output logic [NUM_LANES-1:0]                         dcache_req_rw_o,
    output logic [NUM_LANES-1:0][3:0]                    dcache_req_byteen_o,
    output logic [NUM_LANES-1:0][29:0]                   dcache_req_addr_o,
    output logic [NUM_LANES-1:0][31:0]                   dcache_req_data_o,
    output logic [NUM_LANES-1:0][TAG_OUT_WIDTH-1:0]      dcache_req_tag_o,
    input  logic [NUM_LANES-1:0]                         dcache_req_ready_i,
    input  logic                                         dcache_rsp_valid_i,
    input  logic [NUM_LANES-1:0]                         dcache_rsp_tmask_i,
    input  logic [NUM_LANES-1:0][31:0]                   dcache_rsp_data_i,
    input  logic [TAG_OUT_WIDTH-1:0]                     dcache_rsp_tag_i,
    output logic                                         dcache_rsp_ready_o,
    output logic [NUM_REQS-1:0]                          rsp_valid_o,
    output logic [NUM_LANES-1:0]                         rsp_tmask_o,
    output logic [NUM_LANES-1:0][31:0]                   rsp_data_o,
    output logic [TAG_IN_WIDTH-1:0]                      rsp_tag_o,
    input  logic [NUM_REQS-1:0]                          rsp_ready_i
`ifdef DCACHE_ARB_PERF_EN
    ,
    output logic [43:0]                                  perf_stalls_o
`endif
);

    arb_state_e state_q, state_d;
    logic [NUM_LANES-1:0] pending_q, pending_d;
    logic [NUM_LANES-1:0] pending_left;

    logic                            rw_q;
    logic [SEL_BITS-1:0]             sel_q;
    logic [TAG_IN_WIDTH-1:0]         tag_q;
    logic [NUM_LANES-1:0][3:0]       byteen_q;
    logic [NUM_LANES-1:0][29:0]      addr_q;
    logic [NUM_LANES-1:0][31:0]      data_q;

    logic                            can_accept;
    logic                            grant_en;
    logic                            grant_valid;
    logic                            take;
    logic [NUM_REQS-1:0]             grant_onehot;
    logic [SEL_BITS-1:0]             win_idx;

    assign pending_left = pending_q & ~dcache_req_ready_i;

    // A new request may enter in the same cycle the last lanes drain.
    assign can_accept = (state_q == S_IDLE) || (pending_left == '0);
    assign grant_en   = can_accept && !reset_i;
    assign take       = grant_en && grant_valid;

    vx_dcache_arb_rr #(
        .NUM_REQS (NUM_REQS)
    ) u_rr (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .requests_i     (req_valid_i),
        .enable_i       (grant_en),
        .grant_valid_o  (grant_valid),
        .grant_onehot_o (grant_onehot),
        .grant_index_o  (win_idx)
    );

    assign req_ready_o = take ? grant_onehot : '0;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            S_IDLE: begin
                pending_d = '0;
            end
            S_BUSY: begin
                pending_d = pending_left;
                if (pending_left == '0) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        // An all-zero mask is consumed here and never reaches BUSY.
        if (take) begin
            pending_d = req_tmask_i[win_idx];
            state_d   = (|req_tmask_i[win_idx]) ? S_BUSY : S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            rw_q      <= 1'b0;
            sel_q     <= '0;
            tag_q     <= '0;
            byteen_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (take) begin
                rw_q     <= req_rw_i[win_idx];
                sel_q    <= win_idx;
                tag_q    <= req_tag_i[win_idx];
                byteen_q <= req_byteen_i[win_idx];
                addr_q   <= req_addr_i[win_idx];
                data_q   <= req_data_i[win_idx];
            end
        end
    end

    always_comb begin
        dcache_req_valid_o = (state_q == S_BUSY) ? pending_q : '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            dcache_req_rw_o[l]     = rw_q;
            dcache_req_byteen_o[l] = byteen_q[l];
            dcache_req_addr_o[l]   = addr_q[l];
            dcache_req_data_o[l]   = data_q[l];
            dcache_req_tag_o[l]    = {tag_q, sel_q};
        end
    end

    logic [SEL_BITS-1:0] rsp_sel;
    logic                rsp_hit;

    assign rsp_sel     = dcache_rsp_tag_i[SEL_BITS-1:0];
    assign rsp_tag_o   = dcache_rsp_tag_i[TAG_OUT_WIDTH-1:SEL_BITS];
    assign rsp_tmask_o = dcache_rsp_tmask_i;
    assign rsp_data_o  = dcache_rsp_data_i;

    // Out-of-range selects are swallowed so the dcache never stalls on them.
    always_comb begin
        rsp_hit            = 1'b0;
        rsp_valid_o        = '0;
        dcache_rsp_ready_o = 1'b1;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rsp_sel == SEL_BITS'(i)) begin
                rsp_hit            = 1'b1;
                rsp_valid_o[i]     = dcache_rsp_valid_i;
                dcache_rsp_ready_o = rsp_ready_i[i];
            end
        end
    end

    a_rsp_sel_range: assert property (
        @(posedge clk_i) disable iff (reset_i)
        dcache_rsp_valid_i |-> rsp_hit
    );

`ifdef DCACHE_ARB_PERF_EN
    logic [43:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_q <= '0;
        end else if ((|req_valid_i) && !(|req_ready_o)) begin
            perf_q <= perf_q + 44'd1;
        end
    end

    assign perf_stalls_o = perf_q;
`endif

endmodule
